// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode and FSM encodings,
// the stored per-channel configuration, and small decode helpers.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STEADY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_BURST  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_STEADY   = 3'd1,
    ST_BLINK_HI = 3'd2,
    ST_BLINK_LO = 3'd3,
    ST_BURST_HI = 3'd4,
    ST_BURST_LO = 3'd5,
    ST_GAP      = 3'd6
  } state_e;

  typedef struct packed {
    mode_e      mode;
    logic [1:0] rate;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{mode: MODE_OFF, rate: 2'd0};

  function automatic int unsigned rate_half(input logic [1:0] rate,
                                            input int unsigned h0,
                                            input int unsigned h1,
                                            input int unsigned h2,
                                            input int unsigned h3);
    int unsigned h;
    case (rate)
      2'd0:    h = h0;
      2'd1:    h = h1;
      2'd2:    h = h2;
      default: h = h3;
    endcase
    return h;
  endfunction

  function automatic state_e entry_state(input mode_e mode);
    state_e s;
    case (mode)
      MODE_STEADY: s = ST_STEADY;
      MODE_BLINK:  s = ST_BLINK_HI;
      MODE_BURST:  s = ST_BURST_HI;
      default:     s = ST_OFF;
    endcase
    return s;
  endfunction

  function automatic logic led_of(input state_e s);
    return (s == ST_STEADY) || (s == ST_BLINK_HI) || (s == ST_BURST_HI);
  endfunction

  // States whose duration is measured in half-periods by the counter.
  function automatic logic is_timed(input state_e s);
    return (s == ST_BLINK_HI) || (s == ST_BLINK_LO) || (s == ST_BURST_HI) ||
           (s == ST_BURST_LO) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Config and LED output bundle of the pattern generator; the master drives
// enable/mode/rate, the slave (generator) drives the LED-side outputs.
interface led_pattern_gen_if #(
  parameter int unsigned NUM_CH = 4
);

  logic                  i_enable;
  logic [2*NUM_CH-1:0]   i_mode;
  logic [2*NUM_CH-1:0]   i_rate_sel;
  logic [NUM_CH-1:0]     o_led_drive;
  logic [NUM_CH-1:0]     o_half_tick;
  logic [NUM_CH-1:0]     o_burst_done;

  modport master (
    output i_enable, i_mode, i_rate_sel,
    input  o_led_drive, o_half_tick, o_burst_done
  );

  modport slave (
    input  i_enable, i_mode, i_rate_sel,
    output o_led_drive, o_half_tick, o_burst_done
  );

endinterface

// File: rtl/led_pattern_channel.sv
// One LED channel: stored {mode,rate}, half-period counter, pattern FSM and
// registered LED output. Any config change or disable restarts the pattern.
module led_pattern_channel
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned c_HALF_0   = 125,
  parameter int unsigned c_HALF_1   = 250,
  parameter int unsigned c_HALF_2   = 1250,
  parameter int unsigned c_HALF_3   = 12500,
  parameter int unsigned BURST_LEN  = 3,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_rate_sel,
  output logic       o_led,
  output logic       o_half_tick,
  output logic       o_burst_done
);

  // One sub-counter serves both the burst pulse count and the gap half count.
  localparam int unsigned SUB_MAX = (BURST_LEN > GAP_HALVES) ? BURST_LEN : GAP_HALVES;
  localparam int unsigned SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;
  localparam logic [SUB_W-1:0] BURST_LAST = SUB_W'(BURST_LEN - 1);
  localparam logic [SUB_W-1:0] GAP_LAST   = SUB_W'(GAP_HALVES - 1);

  cfg_t             cfg_in;
  cfg_t             cfg_q;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic [SUB_W-1:0] sub_cnt;
  logic             led_q;
  logic             restart;
  logic             terminal;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cfg_in       = CFG_RESET;
    cfg_in.mode  = mode_e'(i_mode);
    cfg_in.rate  = i_rate_sel;
    cnt_last     = CNT_W'(rate_half(cfg_q.rate, c_HALF_0, c_HALF_1, c_HALF_2, c_HALF_3) - 1);
    restart      = !i_enable || (cfg_in != cfg_q);
    terminal     = is_timed(state) && (cnt == cnt_last);
    // A restart in the same cycle as a terminal count suppresses the pulses.
    o_half_tick  = terminal && !restart;
    o_burst_done = terminal && !restart && (state == ST_GAP) && (sub_cnt == GAP_LAST);
  end

  assign o_led = led_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cfg_q   <= CFG_RESET;
      state   <= ST_OFF;
      cnt     <= '0;
      sub_cnt <= '0;
      led_q   <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      sub_cnt <= '0;
      if (i_enable) begin
        cfg_q <= cfg_in;
        state <= entry_state(cfg_in.mode);
        led_q <= led_of(entry_state(cfg_in.mode));
      end else begin
        // Parking the stored cfg at off/rate0 forces a restart on re-enable.
        cfg_q <= CFG_RESET;
        state <= ST_OFF;
        led_q <= 1'b0;
      end
    end else if (terminal) begin
      cnt <= '0;
      case (state)
        ST_BLINK_HI: begin
          state <= ST_BLINK_LO;
          led_q <= 1'b0;
        end
        ST_BLINK_LO: begin
          state <= ST_BLINK_HI;
          led_q <= 1'b1;
        end
        ST_BURST_HI: begin
          state <= ST_BURST_LO;
          led_q <= 1'b0;
        end
        ST_BURST_LO: begin
          if (sub_cnt == BURST_LAST) begin
            state   <= ST_GAP;
            sub_cnt <= '0;
            led_q   <= 1'b0;
          end else begin
            state   <= ST_BURST_HI;
            sub_cnt <= sub_cnt + 1'b1;
            led_q   <= 1'b1;
          end
        end
        ST_GAP: begin
          if (sub_cnt == GAP_LAST) begin
            state   <= ST_BURST_HI;
            sub_cnt <= '0;
            led_q   <= 1'b1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
          led_q <= 1'b0;
        end
      endcase
    end else if (is_timed(state)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: NUM_CH independent pattern channels behind a
// global enable, with parameter sanity checks at elaboration.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned c_HALF_0   = 125,
  parameter int unsigned c_HALF_1   = 250,
  parameter int unsigned c_HALF_2   = 1250,
  parameter int unsigned c_HALF_3   = 12500,
  parameter int unsigned BURST_LEN  = 3,
  parameter int unsigned GAP_HALVES = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  led_pattern_gen_if.slave   bus
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("led_pattern_gen: NUM_CH must be 1..16");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("led_pattern_gen: CNT_W out of range");
  end
  if (c_HALF_0 < 1 || c_HALF_1 < 1 || c_HALF_2 < 1 || c_HALF_3 < 1) begin : g_bad_half
    $error("led_pattern_gen: every half-period must be at least 1");
  end
  if (longint'(c_HALF_0) - 1 >= CNT_SPAN || longint'(c_HALF_1) - 1 >= CNT_SPAN ||
      longint'(c_HALF_2) - 1 >= CNT_SPAN || longint'(c_HALF_3) - 1 >= CNT_SPAN) begin : g_cnt_narrow
    $error("led_pattern_gen: CNT_W too small for a half-period");
  end
  if (BURST_LEN < 1 || GAP_HALVES < 1) begin : g_bad_burst
    $error("led_pattern_gen: BURST_LEN and GAP_HALVES must be at least 1");
  end

  logic [NUM_CH-1:0] led_raw;
  logic [NUM_CH-1:0] tick_raw;
  logic [NUM_CH-1:0] done_raw;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_pattern_channel #(
      .CNT_W      (CNT_W),
      .c_HALF_0   (c_HALF_0),
      .c_HALF_1   (c_HALF_1),
      .c_HALF_2   (c_HALF_2),
      .c_HALF_3   (c_HALF_3),
      .BURST_LEN  (BURST_LEN),
      .GAP_HALVES (GAP_HALVES)
    ) u_ch (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_enable     (bus.i_enable),
      .i_mode       (bus.i_mode[2*c+1:2*c]),
      .i_rate_sel   (bus.i_rate_sel[2*c+1:2*c]),
      .o_led        (led_raw[c]),
      .o_half_tick  (tick_raw[c]),
      .o_burst_done (done_raw[c])
    );
  end

  // The registered LED lags enable by a cycle; gating blanks it immediately.
  assign bus.o_led_drive  = led_raw & {NUM_CH{bus.i_enable}};
  assign bus.o_half_tick  = tick_raw;
  assign bus.o_burst_done = done_raw;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios plus random
// config traffic against a position-in-pattern reference model.
module tb_led_pattern_gen;

  localparam int NUM_CH = 4;
  localparam int H0 = 2, H1 = 3, H2 = 5, H3 = 8;
  localparam int BL = 2, GH = 3;

  logic i_clock = 1'b0;
  logic i_reset;

  led_pattern_gen_if #(.NUM_CH(NUM_CH)) bus ();

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .CNT_W(8),
    .c_HALF_0(H0), .c_HALF_1(H1), .c_HALF_2(H2), .c_HALF_3(H3),
    .BURST_LEN(BL), .GAP_HALVES(GH)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  // Reference model: active config, restart cycle, and a held-off flag.
  int         now = 0;
  logic [1:0] act_mode [NUM_CH];
  logic [1:0] act_rate [NUM_CH];
  bit         held     [NUM_CH];
  int         t0       [NUM_CH];

  function automatic int half_of(input logic [1:0] r);
    case (r)
      2'd0:    return H0;
      2'd1:    return H1;
      2'd2:    return H2;
      default: return H3;
    endcase
  endfunction

  function automatic bit restart_due(input int c);
    return !i_reset && bus.i_enable &&
           (held[c] || bus.i_mode[2*c +: 2] != act_mode[c] || bus.i_rate_sel[2*c +: 2] != act_rate[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      act_mode[c] = 2'b00;
      act_rate[c] = 2'd0;
      held[c]     = 1'b0;
      t0[c]       = 0;
    end
  endtask

  task automatic model_expect(output logic [NUM_CH-1:0] el, output logic [NUM_CH-1:0] et,
                              output logic [NUM_CH-1:0] ed);
    el = '0; et = '0; ed = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int h, n, per, m;
      if (i_reset || !bus.i_enable || held[c]) continue;
      h = half_of(act_rate[c]);
      n = now - t0[c] - 1;
      case (act_mode[c])
        2'b01: el[c] = 1'b1;
        2'b10: begin
          el[c] = ((n / h) % 2 == 0);
          et[c] = (n % h == h - 1);
        end
        2'b11: begin
          per   = (2 * BL + GH) * h;
          m     = n % per;
          el[c] = (m / h < 2 * BL) && ((m / h) % 2 == 0);
          et[c] = (m % h == h - 1);
          ed[c] = (m == per - 1);
        end
        default: ;
      endcase
      if (restart_due(c)) begin
        et[c] = 1'b0;
        ed[c] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    if (i_reset) model_reset();
    else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!bus.i_enable) held[c] = 1'b1;
        else if (restart_due(c)) begin
          act_mode[c] = bus.i_mode[2*c +: 2];
          act_rate[c] = bus.i_rate_sel[2*c +: 2];
          t0[c]       = now;
          held[c]     = 1'b0;
        end
      end
    end
    now++;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(output logic [NUM_CH-1:0] ol, output logic [NUM_CH-1:0] ot,
                      output logic [NUM_CH-1:0] od, output logic [NUM_CH-1:0] el,
                      output logic [NUM_CH-1:0] et, output logic [NUM_CH-1:0] ed);
    #1;
    ol = bus.o_led_drive;
    ot = bus.o_half_tick;
    od = bus.o_burst_done;
    model_expect(el, et, ed);
    @(posedge i_clock);
    model_update();
    @(negedge i_clock);
  endtask

  task automatic set_ch(input int c, input logic [1:0] m, input logic [1:0] r);
    bus.i_mode[2*c +: 2]     = m;
    bus.i_rate_sel[2*c +: 2] = r;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    logic [6:0] pat;
    pat = 7'b0110011;
    step(ol, ot, od, el, et, ed);
    total++;
    if ({ol, ot, od} !== '0) begin
      bad++;
      $display("FAIL reset_state got led=%b tick=%b done=%b want all 0", ol, ot, od);
    end
    i_reset = 1'b0;
    set_ch(0, 2'b10, 2'd0);
    for (int i = 0; i < 9; i++) begin
      step(ol, ot, od, el, et, ed);
      total += 2;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL reset_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
      if (i < 7 && ol[0] !== pat[6-i]) begin
        bad++;
        $display("FAIL reset_blink_seq i=%0d got %b want %b", i, ol[0], pat[6-i]);
      end
    end
    // Pattern position 8 is a high phase; reset must clear it mid-cycle.
    #1;
    total++;
    if (bus.o_led_drive[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_high got %b want 1", bus.o_led_drive[0]);
    end
    #1 i_reset = 1'b1;
    #1;
    total++;
    if ({bus.o_led_drive, bus.o_half_tick, bus.o_burst_done} !== '0) begin
      bad++;
      $display("FAIL reset_async got led=%b tick=%b done=%b want all 0",
               bus.o_led_drive, bus.o_half_tick, bus.o_burst_done);
    end
    @(posedge i_clock);
    model_update();
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(ol, ot, od, el, et, ed);
      total += 2;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL reset_release_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
      if (ol[0] !== pat[6-i]) begin
        bad++;
        $display("FAIL reset_release_seq i=%0d got %b want %b", i, ol[0], pat[6-i]);
      end
    end
  endtask

  task automatic test_tick_rates();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    int last0, last1;
    last0 = -1; last1 = -1;
    set_ch(0, 2'b10, 2'd1);
    set_ch(1, 2'b10, 2'd3);
    for (int i = 0; i < 50; i++) begin
      step(ol, ot, od, el, et, ed);
      total++;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL rates_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
      if (i > 0 && ot[0]) begin
        if (last0 >= 0) begin
          total++;
          if (i - last0 != 3) begin
            bad++;
            $display("FAIL rates_tick0_gap got %0d want 3", i - last0);
          end
        end
        last0 = i;
      end
      if (i > 0 && ot[1]) begin
        if (last1 >= 0) begin
          total++;
          if (i - last1 != 8) begin
            bad++;
            $display("FAIL rates_tick1_gap got %0d want 8", i - last1);
          end
        end
        last1 = i;
      end
    end
  endtask

  task automatic test_burst();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    logic [13:0] pat;
    pat = 14'b11001100000000;
    set_ch(2, 2'b11, 2'd0);
    step(ol, ot, od, el, et, ed);
    for (int i = 0; i < 28; i++) begin
      step(ol, ot, od, el, et, ed);
      total += 3;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL burst_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
      if (ol[2] !== pat[13 - (i % 14)]) begin
        bad++;
        $display("FAIL burst_led i=%0d got %b want %b", i, ol[2], pat[13 - (i % 14)]);
      end
      if (od[2] !== (i % 14 == 13)) begin
        bad++;
        $display("FAIL burst_done i=%0d got %b want %b", i, od[2], (i % 14 == 13));
      end
    end
  endtask

  task automatic test_rate_change();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    logic prev;
    bit found;
    prev = 1'b0; found = 1'b0;
    set_ch(0, 2'b10, 2'd1);
    for (int i = 0; i < 20 && !found; i++) begin
      step(ol, ot, od, el, et, ed);
      total++;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL ratechg_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
      if (i > 0) begin
        if (prev && !ol[0]) found = 1'b1;
        prev = ol[0];
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL ratechg_find got no falling edge want one within 20 cycles");
    end else begin
      // Second low cycle of a 3-cycle low phase: not a terminal count.
      set_ch(0, 2'b10, 2'd2);
      step(ol, ot, od, el, et, ed);
      total++;
      if (ot[0] !== 1'b0 || ol[0] !== 1'b0) begin
        bad++;
        $display("FAIL ratechg_cycle got led=%b tick=%b want 0/0", ol[0], ot[0]);
      end
      for (int i = 0; i < 6; i++) begin
        step(ol, ot, od, el, et, ed);
        total += 2;
        if ({ol, ot, od} !== {el, et, ed}) begin
          bad++;
          $display("FAIL ratechg_model2 i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
        end
        if (ol[0] !== (i < 5)) begin
          bad++;
          $display("FAIL ratechg_high5 i=%0d got %b want %b", i, ol[0], (i < 5));
        end
      end
      for (int i = 0; i < 3; i++) step(ol, ot, od, el, et, ed);
      // Last cycle of the 5-cycle low phase, changed to steady at the same time.
      set_ch(0, 2'b01, 2'd2);
      step(ol, ot, od, el, et, ed);
      total++;
      if (ot[0] !== 1'b0 || ol[0] !== 1'b0) begin
        bad++;
        $display("FAIL ratechg_terminal got led=%b tick=%b want 0/0", ol[0], ot[0]);
      end
      step(ol, ot, od, el, et, ed);
      total++;
      if (ol[0] !== 1'b1 || ot[0] !== 1'b0) begin
        bad++;
        $display("FAIL ratechg_steady got led=%b tick=%b want 1/0", ol[0], ot[0]);
      end
    end
  endtask

  task automatic test_enable();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'b10, 2'd0);
    for (int i = 0; i < 7; i++) begin
      step(ol, ot, od, el, et, ed);
      total++;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL enable_model i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
    end
    bus.i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(ol, ot, od, el, et, ed);
      total++;
      if ({ol, ot, od} !== '0) begin
        bad++;
        $display("FAIL enable_low i=%0d got %b/%b/%b want all 0", i, ol, ot, od);
      end
    end
    bus.i_enable = 1'b1;
    step(ol, ot, od, el, et, ed);
    total++;
    if (ol !== '0) begin
      bad++;
      $display("FAIL enable_restart_cycle got %b want 0000", ol);
    end
    step(ol, ot, od, el, et, ed);
    total++;
    if (ol !== '1) begin
      bad++;
      $display("FAIL enable_aligned got %b want 1111", ol);
    end
  endtask

  task automatic test_steady_toggle();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    logic prev_steady;
    prev_steady = 1'b0;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < NUM_CH; c++) set_ch(c, (i % 2 == 0) ? 2'b01 : 2'b00, 2'(i % 4));
      step(ol, ot, od, el, et, ed);
      if (i > 0) begin
        total++;
        if (ol !== {NUM_CH{prev_steady}} || ot !== '0 || od !== '0) begin
          bad++;
          $display("FAIL toggle i=%0d got %b/%b/%b want %b/0/0", i, ol, ot, od, {NUM_CH{prev_steady}});
        end
      end
      prev_steady = (i % 2 == 0);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] ol, ot, od, el, et, ed;
    int off_left;
    off_left = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0)
        set_ch(int'($urandom_range(NUM_CH - 1)), 2'($urandom_range(3)), 2'($urandom_range(3)));
      if (off_left > 0) begin
        off_left--;
        bus.i_enable = (off_left == 0);
      end else if ($urandom_range(39) == 0) begin
        off_left = int'($urandom_range(4, 1));
        bus.i_enable = 1'b0;
      end
      step(ol, ot, od, el, et, ed);
      total++;
      if ({ol, ot, od} !== {el, et, ed}) begin
        bad++;
        $display("FAIL random i=%0d got %b/%b/%b want %b/%b/%b", i, ol, ot, od, el, et, ed);
      end
    end
  endtask

  initial begin
    i_reset        = 1'b1;
    bus.i_enable   = 1'b1;
    bus.i_mode     = '0;
    bus.i_rate_sel = '0;
    model_reset();
    @(negedge i_clock);
    test_reset();
    test_tick_rates();
    test_burst();
    test_rate_change();
    test_enable();
    test_steady_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
